// File: rtl/wb_ser_pkg.sv
// Shared definitions for the two-port Wishbone serializer scheduler.
//
// Contents:
//   state_t    - scheduler FSM states
//   ADR_DATA   - serializer data register (a write loads and starts it)
//   ADR_STAT   - serializer status register (read only)
//   STAT_BUSY  - bit of the status word that reads 1 while still shifting
package wb_ser_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        POLL = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int ADR_DATA  = 0;
    localparam int ADR_STAT  = 1;
    localparam int STAT_BUSY = 0;

endpackage

// File: rtl/wb_ser_rr_arb.sv
// Two-way round-robin arbiter.
//
// Ports:
//   req     - request from port 0 / port 1
//   ptr     - port that wins when both request
//   gnt     - one-hot grant (zero when nobody requests)
//   ptr_nxt - pointer to load when the grant is taken
//
// The pointer only moves on contention: a lone requester is granted without
// disturbing the priority order, and after a contested grant the loser gets
// priority next time.
module wb_ser_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    always_comb begin
        gnt     = 2'b00;
        ptr_nxt = ptr;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt     = ptr ? 2'b10 : 2'b01;
                ptr_nxt = ~ptr;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_ser_sched.sv
// Two-requester scheduler in front of a Wishbone-attached serializer.
// A granted word is written to ADR_DATA, then ADR_STAT is polled until the
// busy bit clears (done) or an error/timeout/poll limit aborts it (err).
//
// Ports:
//   CLK_I, RST_NI      - clock (rising edge), async active-low reset
//   req_i, req_dat_i   - per-port request and word (port k at [k*DW +: DW])
//   gnt_o              - one-cycle pulse: port k word captured
//   done_o, err_o      - one-cycle pulse: port k transfer finished / aborted
//   CYC_O .. DAT_O     - Wishbone master outputs
//   DAT_I, ACK_I, ERR_I- Wishbone slave responses
//
// Requester handshake: req_i[k] acts as valid and must stay high with its
// word stable until gnt_o[k] pulses; that pulse is the acceptance, after
// which the requester may drop or change the request. Requests are only
// looked at while IDLE.
module wb_ser_sched
    import wb_ser_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int TMO      = 255,
    parameter int POLL_MAX = 1023
) (
    input  logic            CLK_I,
    input  logic            RST_NI,
    input  logic [1:0]      req_i,
    input  logic [2*DW-1:0] req_dat_i,
    output logic [1:0]      gnt_o,
    output logic [1:0]      done_o,
    output logic [1:0]      err_o,
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    output logic [AW-1:0]   ADR_O,
    output logic [DW-1:0]   DAT_O,
    input  logic [DW-1:0]   DAT_I,
    input  logic            ACK_I,
    input  logic            ERR_I
);

    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    state_t          state;
    state_t          state_nxt;
    logic            owner;
    logic [DW-1:0]   word;
    logic            ptr;
    logic [1:0]      gnt_r;
    logic [TW-1:0]   tmo_cnt;
    logic [PW-1:0]   poll_cnt;

    logic [1:0]      arb_req;
    logic [1:0]      arb_gnt;
    logic            arb_ptr_nxt;
    logic            bus_act;
    logic            timeout;
    logic            busy;
    logic            poll_lim;
    logic            dat_unused;

    // Only the busy bit of the status word matters.
    assign dat_unused = ^DAT_I;

    assign arb_req = (state == IDLE) ? req_i : 2'b00;

    wb_ser_rr_arb u_arb (
        .req     (arb_req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .ptr_nxt (arb_ptr_nxt)
    );

    assign bus_act  = (state == WR) || (state == POLL);
    // Counter is zero on the first strobe cycle, so this fires on the TMO-th
    // strobe cycle that still has no response.
    assign timeout  = bus_act && !ACK_I && !ERR_I && (tmo_cnt == TW'(TMO - 1));
    assign busy     = DAT_I[STAT_BUSY];
    assign poll_lim = (poll_cnt == PW'(POLL_MAX - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (arb_gnt != 2'b00) state_nxt = WR;
            WR: begin
                if (ERR_I)        state_nxt = ERR;
                else if (ACK_I)   state_nxt = GAP;
                else if (timeout) state_nxt = ERR;
            end
            POLL: begin
                if (ERR_I)        state_nxt = ERR;
                else if (ACK_I)   state_nxt = busy ? (poll_lim ? ERR : GAP) : DONE;
                else if (timeout) state_nxt = ERR;
            end
            GAP:     state_nxt = POLL;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state    <= IDLE;
            owner    <= 1'b0;
            word     <= '0;
            ptr      <= 1'b0;
            gnt_r    <= 2'b00;
            tmo_cnt  <= '0;
            poll_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gnt_r   <= arb_gnt;
            // Strobe is low in every state that precedes WR or POLL, so this
            // restarts the count on each strobe rise.
            tmo_cnt <= bus_act ? tmo_cnt + TW'(1) : '0;
            if (arb_gnt != 2'b00) begin
                owner    <= arb_gnt[1];
                word     <= arb_gnt[1] ? req_dat_i[DW +: DW] : req_dat_i[0 +: DW];
                ptr      <= arb_ptr_nxt;
                poll_cnt <= '0;
            end else if (state == POLL && ACK_I && !ERR_I && busy) begin
                poll_cnt <= poll_cnt + PW'(1);
            end
        end
    end

    // Bus outputs decode straight from the state register, so an async reset
    // drops them in the same cycle.
    assign CYC_O  = bus_act;
    assign STB_O  = bus_act;
    assign WE_O   = (state == WR);
    assign ADR_O  = (state == POLL) ? AW'(ADR_STAT) : AW'(ADR_DATA);
    assign DAT_O  = (state == WR) ? word : '0;
    assign gnt_o  = gnt_r;
    assign done_o = (state == DONE) ? {owner, ~owner} : 2'b00;
    assign err_o  = (state == ERR)  ? {owner, ~owner} : 2'b00;

endmodule

// File: tb/tb_wb_ser_sched.sv
// Bench for wb_ser_sched: a registered Wishbone slave model, a transaction
// level predictor that fills expected queues, one compare process, and a few
// hand-computed literal checks on timing and ordering.
module tb_wb_ser_sched;

    localparam int DW       = 8;
    localparam int AW       = 2;
    localparam int TMO      = 4;
    localparam int POLL_MAX = 5;
    localparam int OW       = 1 + AW + DW;

    localparam int MODE_OK     = 0;
    localparam int MODE_ERR_WR = 1;
    localparam int MODE_NORESP = 2;

    logic            CLK_I = 1'b0;
    logic            RST_NI = 1'b0;
    logic [1:0]      req_i = 2'b00;
    logic [2*DW-1:0] req_dat_i = '0;
    logic [1:0]      gnt_o, done_o, err_o;
    logic            CYC_O, STB_O, WE_O;
    logic [AW-1:0]   ADR_O;
    logic [DW-1:0]   DAT_O;
    logic [DW-1:0]   DAT_I;
    logic            ACK_I, ERR_I;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OW-1:0] exp_bus_q[$];
    logic [1:0]    exp_gnt_q[$];
    logic [2:0]    exp_end_q[$];

    int   slv_mode   = MODE_OK;
    int   slv_busy_n = 0;
    int   rd_idx;
    logic m_ptr = 1'b0;

    logic in_xfer = 1'b0;
    logic cyc_q = 1'b0;
    int   stb_run = 0;
    int   last_stb_run = 0;
    int   cyc_low = 0;
    int   n_cyc_rise = 0;
    logic [1:0] first_gnt;
    int   lat;

    wb_ser_sched #(.DW(DW), .AW(AW), .TMO(TMO), .POLL_MAX(POLL_MAX)) dut (
        .CLK_I     (CLK_I),
        .RST_NI    (RST_NI),
        .req_i     (req_i),
        .req_dat_i (req_dat_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .CYC_O     (CYC_O),
        .STB_O     (STB_O),
        .WE_O      (WE_O),
        .ADR_O     (ADR_O),
        .DAT_O     (DAT_O),
        .DAT_I     (DAT_I),
        .ACK_I     (ACK_I),
        .ERR_I     (ERR_I)
    );

    // ---------------- clock ----------------
    always #5 CLK_I = ~CLK_I;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- registered slave: answers the cycle after a strobe ----------------
    always @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            ACK_I  <= 1'b0;
            ERR_I  <= 1'b0;
            DAT_I  <= '0;
            rd_idx <= 0;
        end else begin
            ACK_I <= 1'b0;
            ERR_I <= 1'b0;
            DAT_I <= '0;
            if (CYC_O && STB_O && !ACK_I && !ERR_I && slv_mode != MODE_NORESP) begin
                if (WE_O) begin
                    rd_idx <= 0;
                    ACK_I  <= 1'b1;
                    if (slv_mode == MODE_ERR_WR) ERR_I <= 1'b1;
                end else begin
                    ACK_I  <= 1'b1;
                    DAT_I  <= (rd_idx < slv_busy_n) ? DW'(1) : DW'(0);
                    rd_idx <= rd_idx + 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK_I) begin
        if (RST_NI) begin
            logic [OW-1:0] e;
            logic [2:0]    ee;
            check("stb_without_cyc", {31'd0, STB_O & ~CYC_O}, 32'd0);
            check("gnt_onehot",  {31'd0, $countones(gnt_o)  <= 1}, 32'd1);
            check("done_onehot", {31'd0, $countones(done_o) <= 1}, 32'd1);
            check("err_onehot",  {31'd0, $countones(err_o)  <= 1}, 32'd1);

            if (gnt_o != 2'b00) begin
                if (exp_gnt_q.size() == 0) check("unexpected_gnt", {30'd0, gnt_o}, 32'd0);
                else check("gnt", {30'd0, gnt_o}, {30'd0, exp_gnt_q.pop_front()});
                if (first_gnt == 2'b00) first_gnt = gnt_o;
                in_xfer    = 1'b1;
                n_cyc_rise = 0;
            end

            if (CYC_O && STB_O && (ACK_I || ERR_I)) begin
                if (exp_bus_q.size() == 0) begin
                    check("unexpected_bus_cycle", {31'd0, ACK_I | ERR_I}, 32'd0);
                end else begin
                    e = exp_bus_q.pop_front();
                    check("bus_we",  {31'd0, WE_O}, {31'd0, e[OW-1]});
                    check("bus_adr", 32'(ADR_O), 32'(e[DW +: AW]));
                    if (e[OW-1]) check("bus_dat", 32'(DAT_O), 32'(e[DW-1:0]));
                end
            end

            if ((done_o | err_o) != 2'b00) begin
                if (exp_end_q.size() == 0) begin
                    check("unexpected_end", {28'd0, done_o, err_o}, 32'd0);
                end else begin
                    ee = exp_end_q.pop_front();
                    check("end", {29'd0, err_o != 2'b00, done_o | err_o}, {29'd0, ee});
                end
                in_xfer = 1'b0;
            end

            if (CYC_O && !cyc_q) begin
                n_cyc_rise++;
                if (in_xfer && n_cyc_rise > 1) check("cyc_gap_len", cyc_low, 1);
            end
            cyc_low = CYC_O ? 0 : cyc_low + 1;
            cyc_q   = CYC_O;

            if (STB_O) stb_run++;
            else if (stb_run != 0) begin
                last_stb_run = stb_run;
                stb_run      = 0;
            end
        end
    end

    // ---------------- driver: predict, then drive one request pattern ----------------
    task automatic run(input logic [1:0] req, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input int busy, input int mode);
        logic [1:0] pend;
        logic       g;
        int         n_rd;
        int         cyc;
        pend = req;
        n_rd = (busy < POLL_MAX) ? busy + 1 : POLL_MAX;
        while (pend != 2'b00) begin
            if (pend == 2'b11) begin
                g     = m_ptr;
                m_ptr = ~m_ptr;
            end else begin
                g = pend[1];
            end
            pend[g] = 1'b0;
            exp_gnt_q.push_back(g ? 2'b10 : 2'b01);
            if (mode != MODE_NORESP) exp_bus_q.push_back({1'b1, AW'(0), g ? w1 : w0});
            if (mode == MODE_OK)
                for (int i = 0; i < n_rd; i++) exp_bus_q.push_back({1'b0, AW'(1), DW'(0)});
            exp_end_q.push_back({(mode != MODE_OK) || (busy >= POLL_MAX), g, ~g});
        end
        slv_mode   = mode;
        slv_busy_n = busy;
        @(negedge CLK_I);
        req_dat_i = {w1, w0};
        req_i     = req;
        first_gnt = 2'b00;
        lat       = 0;
        cyc       = 0;
        while ((req_i != 2'b00 || exp_end_q.size() != 0) && cyc < 400) begin
            @(negedge CLK_I);
            cyc++;
            if (gnt_o != 2'b00) req_i = req_i & ~gnt_o;
            if (lat == 0 && (done_o | err_o) != 2'b00) lat = cyc;
        end
        if (cyc >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got %0d cycles without completion, required under 400", cyc);
            req_i = 2'b00;
            exp_gnt_q.delete();
            exp_bus_q.delete();
            exp_end_q.delete();
        end
        repeat (2) @(negedge CLK_I);
        check("bus_q_drained", exp_bus_q.size(), 0);
        check("gnt_q_drained", exp_gnt_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int found;
        repeat (2) @(negedge CLK_I);
        check("rst_cyc",  {31'd0, CYC_O}, 32'd0);
        check("rst_stb",  {31'd0, STB_O}, 32'd0);
        check("rst_we",   {31'd0, WE_O},  32'd0);
        check("rst_adr",  32'(ADR_O), 32'd0);
        check("rst_dat",  32'(DAT_O), 32'd0);
        check("rst_gnt",  32'(gnt_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err",  32'(err_o), 32'd0);
        RST_NI = 1'b1;

        // single port, not busy: 6 cycles to done, read cycle is 2 strobe cycles
        run(2'b01, 8'hA5, 8'h00, 0, MODE_OK);
        check("lat_simple", lat, 6);
        check("stb_len_simple", last_stb_run, 2);
        check("bus_cycles_simple", n_cyc_rise, 2);

        // contention after reset: port 0 first, then port 1 first next time
        run(2'b11, 8'h11, 8'h22, 0, MODE_OK);
        check("first_gnt_both_a", 32'(first_gnt), 32'h1);
        run(2'b11, 8'h33, 8'h44, 0, MODE_OK);
        check("first_gnt_both_b", 32'(first_gnt), 32'h2);

        // three busy replies: one write plus four reads
        run(2'b01, 8'h5C, 8'h00, 3, MODE_OK);
        check("bus_cycles_busy3", n_cyc_rise, 5);

        // ERR with ACK on the write: abort, no status read
        run(2'b10, 8'h00, 8'h77, 0, MODE_ERR_WR);
        check("bus_cycles_errwr", n_cyc_rise, 1);

        // silent slave: strobe held TMO cycles, err one cycle later
        run(2'b01, 8'h99, 8'h00, 0, MODE_NORESP);
        check("stb_len_timeout", last_stb_run, 4);
        check("lat_timeout", lat, 5);

        // busy forever: POLL_MAX reads then abort
        run(2'b10, 8'h00, 8'hC3, 10, MODE_OK);
        check("bus_cycles_pollmax", n_cyc_rise, 6);

        // reset during POLL
        slv_mode   = MODE_OK;
        slv_busy_n = 3;
        exp_gnt_q.push_back(2'b01);
        exp_bus_q.push_back({1'b1, AW'(0), 8'h5A});
        @(negedge CLK_I);
        req_dat_i = {8'h00, 8'h5A};
        req_i     = 2'b01;
        found     = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge CLK_I);
            if (gnt_o != 2'b00) req_i = req_i & ~gnt_o;
            if (CYC_O && STB_O && !WE_O) found = 1;
        end
        check("reached_poll", found, 1);
        #2 RST_NI = 1'b0;
        #1;
        check("rst_mid_cyc", {31'd0, CYC_O}, 32'd0);
        check("rst_mid_stb", {31'd0, STB_O}, 32'd0);
        check("rst_mid_done", 32'(done_o | err_o), 32'd0);
        exp_gnt_q.delete();
        exp_bus_q.delete();
        exp_end_q.delete();
        m_ptr      = 1'b0;
        in_xfer    = 1'b0;
        n_cyc_rise = 0;
        stb_run    = 0;
        cyc_q      = 1'b0;
        req_i      = 2'b00;
        repeat (2) @(negedge CLK_I);
        RST_NI = 1'b1;
        found  = 0;
        repeat (8) begin
            @(negedge CLK_I);
            if ((done_o | err_o) != 2'b00) found++;
        end
        check("no_end_after_reset", found, 0);

        run(2'b10, 8'h00, 8'h3C, 0, MODE_OK);
        check("post_reset_gnt", 32'(first_gnt), 32'h2);
        check("post_reset_lat", lat, 6);

        check("end_q_drained", exp_end_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ser_sched.md
WB_SER_SCHED -- requirements
Module: wb_ser_sched

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the data word width of the requesters and the Wishbone bus.
REQ-002 SHALL have parameter AW, default 2, meaning the Wishbone address width.
REQ-003 SHALL have parameter TMO, default 255, meaning the maximum cycles to wait for ACK_I/ERR_I per bus cycle.
REQ-004 SHALL have parameter POLL_MAX, default 1023, meaning the maximum status reads per transfer.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have the following ports:
- CLK_I  in  1  clock; all logic on the rising edge
- RST_NI  in  1  asynchronous active-low reset
- req_i  in  2  per-requester transfer request; held until granted
- req_dat_i  in  2*DW  requester words; port k occupies bits [k*DW +: DW]
- gnt_o  out  2  one-cycle pulse: word of port k captured
- done_o  out  2  one-cycle pulse: port k word fully serialized
- err_o  out  2  one-cycle pulse: port k transfer aborted
- CYC_O, STB_O, WE_O  out  1 each  Wishbone master strobes
- ADR_O  out  AW  Wishbone address
- DAT_O  out  DW  Wishbone write data
- DAT_I  in  DW  Wishbone read data
- ACK_I, ERR_I  in  1 each  Wishbone slave responses

Function
REQ-007 SHALL drive serializer map constants: ADR_DATA=0 (write loads and starts), ADR_STAT=1 (read; DAT_I[0]=busy).
REQ-008 SHALL implement FSM states IDLE, WR, POLL, GAP, DONE, ERR.
REQ-009 SHALL grant in IDLE via 2-way round-robin:
- single request: grant it
- both: grant port ptr
- ptr then points to the non-granted port
REQ-010 SHALL, on grant, register owner and word, pulse gnt_o[owner], and enter WR, all in the cycle after req_i is sampled.
REQ-011 SHALL in WR drive CYC_O=STB_O=WE_O=1, ADR_O=ADR_DATA, DAT_O=captured word, and hold them stable until ACK_I or ERR_I.
REQ-012 SHALL move WR->POLL on ACK_I, deasserting STB_O for one cycle between bus cycles; CYC_O SHALL remain low in that gap.
REQ-013 SHALL in POLL drive CYC_O=STB_O=1, WE_O=0, ADR_O=ADR_STAT.
- ACK_I with DAT_I[0]=0 -> DONE
- ACK_I with DAT_I[0]=1 -> GAP (CYC_O=0, one cycle) -> POLL
REQ-014 SHALL treat ERR_I in WR or POLL as an abort -> ERR; ERR_I SHALL win over a simultaneous ACK_I.
REQ-015 SHALL count cycles per bus cycle, cleared on STB_O rise; reaching TMO with no response -> ERR, with CYC_O/STB_O dropped.
REQ-016 SHALL count polls per transfer; the POLL_MAX-th busy=1 reply -> ERR.
REQ-017 SHALL in DONE pulse done_o[owner] one cycle and return to IDLE; in ERR pulse err_o[owner] one cycle and return to IDLE.
REQ-018 SHALL not sample req_i outside IDLE; requests pending across a transfer are arbitrated on the next IDLE cycle.
REQ-019 SHALL never assert STB_O without CYC_O, and SHALL never assert more than one bit of gnt_o, done_o or err_o per cycle.
REQ-020 SHALL complete a transfer with immediate ACK and not-busy in 6 cycles, from req_i sample to done_o pulse inclusive.

Reset
REQ-021 SHALL, on RST_NI low, immediately clear:
- state -> IDLE
- ptr -> 0
- counters -> 0
- CYC_O, STB_O, WE_O, ADR_O, DAT_O, gnt_o, done_o, err_o -> 0
REQ-022 SHALL, on reset mid-transfer, abandon the transfer silently, with no done_o or err_o pulse after release.
REQ-023 SHALL resume arbitration on the first clock edge after RST_NI deasserts.

Structure
REQ-024 SHALL place the state enum, ADR_DATA, ADR_STAT and the STAT_BUSY bit index in package wb_ser_pkg.
REQ-025 SHALL instantiate sub-module wb_ser_rr_arb (2-way round-robin: req, ptr -> one-hot grant, next ptr).

Verification
REQ-026 Port 0 request, word 0xA5, slave ACK next cycle, busy=0 -> one WE write of 0xA5 at ADR 0, one read at ADR 1, done_o[0] pulse; gnt_o[0] one cycle.
REQ-027 Both ports request together (0x11, 0x22) after reset -> port 0 served first, then port 1; a repeated simultaneous request then grants port 1 first.
REQ-028 Status returns busy=1 three times, then 0 -> exactly 4 reads separated by single CYC_O-low cycles; done_o after the 4th ACK.
REQ-029 ERR_I and ACK_I together on the write -> err_o pulse, no status read; with TMO=4 and no response -> CYC_O drops after 4 cycles and err_o pulses.
REQ-030 RST_NI asserted during POLL -> CYC_O/STB_O low in the same cycle, no done_o/err_o; a new request after release is served normally.
